// File: rtl/ring_phase_monitor_pkg.sv
// Shared types and default sizing for the ring phase monitor.
package ring_phase_monitor_pkg;

    // Tracker state: hunting for a first good sample, or following the ring.
    typedef enum logic [0:0] {
        StSync,
        StLocked
    } state_e;

    localparam int unsigned DefWidth = 6;
    localparam int unsigned DefHome  = 3;
    localparam int unsigned DefCntW  = 8;

    // Index width for a WIDTH-stage ring; never narrower than one bit.
    function automatic int unsigned phase_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Sample input and status output bundle of the ring phase monitor.
interface ring_phase_monitor_if
    import ring_phase_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
);

    localparam int unsigned PHASE_W = phase_width(WIDTH);

    logic [WIDTH-1:0]   ring;
    logic               ring_valid;
    logic               clr_err;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               rev_pulse;
    logic [CNT_W-1:0]   rev_count;
    logic               err_onehot;
    logic               err_seq;

    // Upstream side: supplies ring samples and the error clear.
    modport master (
        output ring,
        output ring_valid,
        output clr_err,
        input  phase,
        input  phase_valid,
        input  rev_pulse,
        input  rev_count,
        input  err_onehot,
        input  err_seq
    );

    // Monitor side.
    modport slave (
        input  ring,
        input  ring_valid,
        input  clr_err,
        output phase,
        output phase_valid,
        output rev_pulse,
        output rev_count,
        output err_onehot,
        output err_seq
    );

endinterface

// File: rtl/ring_phase_monitor_onehot_encode.sv
// One-hot to binary index encoder with a popcount==1 qualifier.
module onehot_encode #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [CntW-1:0] cnt;

    // Count set bits and OR together their indices; idx is only meaningful when one-hot.
    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (vec[i]) begin
                cnt = cnt + CntW'(1);
                idx = idx | IDX_W'(i);
            end
        end
        is_onehot = (cnt == CntW'(1));
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Tracks a one-hot ring counter, reports its phase, counts revolutions and
// flags malformed or out-of-sequence samples.
module ring_phase_monitor
    import ring_phase_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned HOME  = DefHome,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic               clk,
    input  logic               rst,
    ring_phase_monitor_if.slave bus
);

    localparam int unsigned PhaseW   = phase_width(WIDTH);
    localparam int unsigned PrevHome = (HOME == 0) ? WIDTH - 1 : HOME - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [PhaseW-1:0]  phase_q, phase_d;
    logic               rev_pulse_q, rev_pulse_d;
    logic [CNT_W-1:0]   rev_count_q, rev_count_d;
    logic               err_onehot_q, err_onehot_d;
    logic               err_seq_q, err_seq_d;

    logic [PhaseW-1:0]  sample_idx;
    logic               sample_onehot;
    logic [WIDTH-1:0]   expected;
    logic               hit_onehot_err;
    logic               hit_seq_err;

    onehot_encode #(
        .WIDTH (WIDTH),
        .IDX_W (PhaseW)
    ) u_encode (
        .vec       (bus.ring),
        .idx       (sample_idx),
        .is_onehot (sample_onehot)
    );

    // Next legal value: previous sample rotated one step toward the higher index.
    assign expected = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};

    // State register; reset discards prev and all status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSync;
            prev_q       <= '0;
            phase_q      <= '0;
            rev_pulse_q  <= 1'b0;
            rev_count_q  <= '0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            phase_q      <= phase_d;
            rev_pulse_q  <= rev_pulse_d;
            rev_count_q  <= rev_count_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
        end
    end

    // Classify the sample against the current state; everything holds without ring_valid.
    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        phase_d        = phase_q;
        rev_pulse_d    = 1'b0;
        rev_count_d    = rev_count_q;
        err_onehot_d   = err_onehot_q;
        err_seq_d      = err_seq_q;
        hit_onehot_err = 1'b0;
        hit_seq_err    = 1'b0;

        if (bus.ring_valid) begin
            case (state_q)
                StSync: begin
                    // First sample after sync only establishes the phase; never a revolution.
                    if (sample_onehot) begin
                        state_d = StLocked;
                        prev_d  = bus.ring;
                        phase_d = sample_idx;
                    end else begin
                        hit_onehot_err = 1'b1;
                    end
                end
                StLocked: begin
                    if (!sample_onehot) begin
                        state_d        = StSync;
                        hit_onehot_err = 1'b1;
                    end else if (bus.ring == expected) begin
                        prev_d  = bus.ring;
                        phase_d = sample_idx;
                        // phase_q still holds the index of prev here.
                        if (sample_idx == PhaseW'(HOME) && phase_q == PhaseW'(PrevHome)) begin
                            rev_pulse_d = 1'b1;
                            rev_count_d = rev_count_q + CNT_W'(1);
                        end
                    end else begin
                        state_d     = StSync;
                        hit_seq_err = 1'b1;
                    end
                end
                default: state_d = StSync;
            endcase

            // Clear first so a simultaneous new error still lands.
            if (bus.clr_err) begin
                err_onehot_d = 1'b0;
                err_seq_d    = 1'b0;
            end
            if (hit_onehot_err) begin
                err_onehot_d = 1'b1;
            end
            if (hit_seq_err) begin
                err_seq_d = 1'b1;
            end
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = (state_q == StLocked);
    assign bus.rev_pulse   = rev_pulse_q;
    assign bus.rev_count   = rev_count_q;
    assign bus.err_onehot  = err_onehot_q;
    assign bus.err_seq     = err_seq_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: an 8-bit-counter instance and a
// 2-bit-counter instance see the same sample stream.
module tb_ring_phase_monitor;
    import ring_phase_monitor_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] drv_ring;
    logic       drv_valid;
    logic       drv_clr;

    int checks = 0;
    int errors = 0;

    ring_phase_monitor_if #(.WIDTH(6), .CNT_W(8)) bus ();
    ring_phase_monitor_if #(.WIDTH(6), .CNT_W(2)) bus2 ();

    assign bus.ring        = drv_ring;
    assign bus.ring_valid  = drv_valid;
    assign bus.clr_err     = drv_clr;
    assign bus2.ring       = drv_ring;
    assign bus2.ring_valid = drv_valid;
    assign bus2.clr_err    = drv_clr;

    ring_phase_monitor #(.WIDTH(6), .HOME(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ring_phase_monitor #(.WIDTH(6), .HOME(3), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ph, input int pv, input int rp,
                           input int rc, input int eo, input int es);
        chk({tag, ".phase"}, 32'(bus.phase), 32'(ph));
        chk({tag, ".phase_valid"}, 32'(bus.phase_valid), 32'(pv));
        chk({tag, ".rev_pulse"}, 32'(bus.rev_pulse), 32'(rp));
        chk({tag, ".rev_count"}, 32'(bus.rev_count), 32'(rc));
        chk({tag, ".err_onehot"}, 32'(bus.err_onehot), 32'(eo));
        chk({tag, ".err_seq"}, 32'(bus.err_seq), 32'(es));
    endtask

    // Apply one cycle of stimulus and settle just past the rising edge.
    task automatic cyc(input logic [5:0] r, input logic v, input logic c);
        drv_ring  = r;
        drv_valid = v;
        drv_clr   = c;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] walk [7];
    int         walk_ph [7];
    int         idx;

    initial begin
        walk    = '{6'b001000, 6'b010000, 6'b100000, 6'b000001, 6'b000010, 6'b000100, 6'b001000};
        walk_ph = '{3, 4, 5, 0, 1, 2, 3};

        // Reset.
        rst = 1'b1;
        cyc(6'b000000, 1'b0, 1'b0);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.rev_count2", 32'(bus2.rev_count), 32'd0);
        rst = 1'b0;

        // One full revolution from HOME; first HOME sample gives no pulse.
        for (int i = 0; i < 7; i++) begin
            cyc(walk[i], 1'b1, 1'b0);
            chk("walk.phase", 32'(bus.phase), 32'(walk_ph[i]));
            chk("walk.phase_valid", 32'(bus.phase_valid), 32'd1);
            chk("walk.rev_pulse", 32'(bus.rev_pulse), (i == 6) ? 32'd1 : 32'd0);
        end
        chk("walk.rev_count", 32'(bus.rev_count), 32'd1);
        chk("walk.rev_count2", 32'(bus2.rev_count), 32'd1);

        // Invalid garbage with ring_valid low is ignored; pulse drops.
        cyc(6'b110011, 1'b0, 1'b0);
        chk_all("gap", 3, 1, 0, 1, 0, 0);

        // Stall then relock.
        cyc(6'b010000, 1'b1, 1'b0);
        chk("pre_stall.phase", 32'(bus.phase), 32'd4);
        cyc(6'b010000, 1'b1, 1'b0);
        chk_all("stall", 4, 0, 0, 1, 0, 1);
        cyc(6'b100000, 1'b1, 1'b0);
        chk_all("relock", 5, 1, 0, 1, 0, 1);

        // Clear with a good sample.
        cyc(6'b000001, 1'b1, 1'b1);
        chk_all("clr_seq", 0, 1, 0, 1, 0, 0);

        // Multi-hot while locked.
        cyc(6'b011000, 1'b1, 1'b0);
        chk_all("multihot", 0, 0, 0, 1, 1, 0);

        // Zero sample together with clear: error wins.
        cyc(6'b000000, 1'b1, 1'b1);
        chk_all("zero_clr", 0, 0, 0, 1, 1, 0);

        // Clear with a good sample, relock at phase 1.
        cyc(6'b000010, 1'b1, 1'b1);
        chk_all("clr_relock", 1, 1, 0, 1, 0, 0);
        cyc(6'b000100, 1'b1, 1'b0);
        chk("to_home.phase", 32'(bus.phase), 32'd2);
        cyc(6'b001000, 1'b1, 1'b0);
        chk("rev2.rev_pulse", 32'(bus.rev_pulse), 32'd1);
        chk("rev2.rev_count", 32'(bus.rev_count), 32'd2);
        chk("rev2.rev_count2", 32'(bus2.rev_count), 32'd2);

        // Two more revolutions with a mid-run gap; 2-bit counter wraps 3 -> 0.
        for (int rev = 0; rev < 2; rev++) begin
            for (int k = 0; k < 6; k++) begin
                idx = (4 + k) % 6;
                cyc(6'(1 << idx), 1'b1, 1'b0);
                chk("revs.phase2", 32'(bus2.phase), 32'(idx));
                chk("revs.rev_pulse2", 32'(bus2.rev_pulse), (k == 5) ? 32'd1 : 32'd0);
                if (k == 2) begin
                    cyc(6'b111111, 1'b0, 1'b1);
                    chk("revs_gap.phase2", 32'(bus2.phase), 32'd0);
                    chk("revs_gap.phase_valid2", 32'(bus2.phase_valid), 32'd1);
                    chk("revs_gap.rev_count2", 32'(bus2.rev_count), 32'(2 + rev));
                    chk("revs_gap.err_onehot2", 32'(bus2.err_onehot), 32'd0);
                end
            end
            chk("revs.rev_count2", 32'(bus2.rev_count), 32'((3 + rev) % 4));
            chk("revs.rev_count", 32'(bus.rev_count), 32'(3 + rev));
        end

        // Advance to phase 1, then reset mid-revolution with valid and clear high.
        cyc(6'b010000, 1'b1, 1'b0);
        cyc(6'b100000, 1'b1, 1'b0);
        cyc(6'b000001, 1'b1, 1'b0);
        cyc(6'b000010, 1'b1, 1'b0);
        chk("pre_rst.phase", 32'(bus.phase), 32'd1);
        rst = 1'b1;
        cyc(6'b000100, 1'b1, 1'b1);
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
        chk("mid_rst.rev_count2", 32'(bus2.rev_count), 32'd0);
        rst = 1'b0;
        cyc(6'b000100, 1'b1, 1'b0);
        chk_all("post_rst", 2, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
